// File: rtl/adcsnap_capture_ctrl_if.sv
// BRAM write port of the ADC snapshot capture path.
interface adcsnap_capture_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;

    modport master (output bram_addr, output bram_data, output bram_we);
    modport slave  (input  bram_addr, input  bram_data, input  bram_we);
endinterface

// File: rtl/adcsnap_capture_ctrl.sv
// Snapshot capture controller: arm on ctrl[0] edge, wait for trigger, write a
// 2^ADDR_W word burst into the snapshot BRAM, and report progress in status.
module adcsnap_capture_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic                    user_clk,
    input  logic                    user_rst_n,
    input  logic [31:0]             ctrl,
    input  logic                    trig,
    input  logic [DATA_W-1:0]       din,
    input  logic                    din_vld,
    adcsnap_capture_ctrl_if.master  bram,
    output logic [31:0]             status
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t          state, state_nxt;
    logic [ADDR_W:0] cnt, cnt_nxt;
    logic            arm_d, arm_ok, arm_pulse, go, wr;
    logic [31:0]     status_nxt;
    logic            ctrl_unused;

    assign ctrl_unused = ^ctrl[31:2];

    // arm_ok blocks a ctrl[0] held high through reset from arming on release.
    assign arm_pulse = ctrl[0] & ~arm_d & arm_ok;
    assign go        = trig | ctrl[1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr        = 1'b0;
        case (state)
            IDLE: begin
                if (arm_pulse) begin
                    state_nxt = ARMED;
                    cnt_nxt   = '0;
                end
            end
            ARMED: begin
                if (arm_pulse) begin
                    cnt_nxt = '0;
                end else if (go) begin
                    state_nxt = CAPTURE;
                    if (din_vld) begin
                        wr      = 1'b1;
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (arm_pulse) begin
                    state_nxt = ARMED;
                    cnt_nxt   = '0;
                end else if (din_vld) begin
                    wr      = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt_nxt == DEPTH) state_nxt = DONE;
                end
            end
            DONE: begin
                if (arm_pulse) begin
                    state_nxt = ARMED;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Status follows the registered state/count, so build it from next values.
        status_nxt = {state_nxt == DONE, state_nxt == ARMED, state_nxt == CAPTURE, 29'b0}
                   | 32'(cnt_nxt);
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            arm_d          <= 1'b0;
            arm_ok         <= 1'b0;
            status         <= '0;
            bram.bram_we   <= 1'b0;
            bram.bram_addr <= '0;
            bram.bram_data <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            arm_d        <= ctrl[0];
            if (!ctrl[0]) arm_ok <= 1'b1;
            status       <= status_nxt;
            bram.bram_we <= wr;
            if (wr) begin
                bram.bram_addr <= cnt[ADDR_W-1:0];
                bram.bram_data <= din;
            end
        end
    end
endmodule
